csr_file_v2: RTL and testbench
==============================

Name: csr_file_v2

Overview:
- Parametrised, writable machine-mode CSR file. Successor to the read-mostly CSR block.
- Adds:
  - a full CSRRW/S/C write path;
  - mstatus MIE/MPIE trap stacking and MRET;
  - mie/mip interrupt gating;
  - mtvec with direct and vectored modes;
  - mscratch;
  - mcycle and minstret counters of configurable width;
  - illegal-access detection.
- Sits beside the execute stage. Reads are combinational; all updates occur on the clock edge.

Parameters:
- HART_ID, 0: value returned by mhartid.
- COUNTER_WIDTH, 64: width of mcycle/minstret. Legal values are 32 or 64. At 32, mcycleh/minstreth read 0 and are write-ignored.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec. Bits [1:0] give the reset mode.
- MISA_VALUE, 32'h4000_0100: constant returned by misa (RV32I).

Ports:
- i_Clock  in  1  clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_CsrNumber  in  12  CSR address.
- i_AluOp  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- i_InputData  in  32  rs1 value or zero-extended uimm.
- i_ReadEnable  in  1  instruction reads the CSR (rd != x0, or any RS/RC).
- i_WriteEnable  in  1  instruction writes the CSR (RW/RWI, or RS/RC with rs1/uimm != 0).
- i_InstructionRetired  in  1  one instruction retired this cycle.
- i_ExceptionRaised  in  1  trap taken this cycle.
- i_Interrupt  in  1  the trap is an interrupt.
- i_ExceptionCause  in  4  trap cause code.
- i_ExceptionInstructionPointer  in  32  PC of the trapping instruction.
- i_ExceptionValue  in  32  value for mtval.
- i_Mret  in  1  MRET executing.
- i_SoftwareIrq / i_TimerIrq / i_ExternalIrq  in  1 each  level interrupt lines.
- o_OutputData  out  32  old CSR value (combinational).
- o_IllegalAccess  out  1  access is illegal (combinational).
- o_mepc  out  32  current mepc.
- o_TrapVector  out  32  target PC for the current trap.
- o_InterruptPending  out  1  equals mstatus.MIE & |(mip & mie).

Behaviour:
- **Implemented CSRs:**
  - Read-only: mvendorid=0, marchid=0, mimpid=0, mhartid=HART_ID.
  - misa: reads MISA_VALUE, writes ignored.
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] hardwired 11. All other bits read 0.
  - mie 0x304: only bits 3/7/11 are writable.
  - mtvec 0x305.
  - mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mip 0x344: read-only. Bit 3=i_SoftwareIrq, bit 7=i_TimerIrq, bit 11=i_ExternalIrq, sampled live.
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
- **Illegal access:** o_IllegalAccess=1 when (i_ReadEnable|i_WriteEnable) and the CSR is unimplemented, or when i_WriteEnable and i_CsrNumber[11:10]==11. An illegal access performs no write. o_OutputData is 0 for unimplemented numbers.
- **New value:**
  - RW/RWI: new = i_InputData.
  - RS/RSI: new = old | i_InputData.
  - RC/RCI: new = old & ~i_InputData.
  - Reserved funct3 000/100: no write, and o_IllegalAccess=1 if enabled.
- **Write commit:** at the clock edge when i_WriteEnable & ~o_IllegalAccess.
  - mepc: bits [1:0] forced to 0.
  - mtvec: mode [1:0] of 2 or 3 keeps the old mode; base bits are still written.
- **Priority per edge:** i_Reset > i_ExceptionRaised > i_Mret > CSR write. A lower-priority event on the same cycle is dropped entirely.
- **Trap entry:**
  - mepc <= {PC[31:2],2'b00}
  - mcause <= {i_Interrupt, 27'b0, cause}
  - mtval <= i_ExceptionValue
  - MPIE <= MIE, MIE <= 0
- **MRET:** MIE <= MPIE, MPIE <= 1.
- **o_TrapVector:**
  - {mtvec[31:2],2'b00} when mode=0 or i_Interrupt=0.
  - In vectored mode with an interrupt: base + 4*cause.
- **Counters:**
  - mcycle increments by 1 every non-reset cycle.
  - minstret increments on i_InstructionRetired.
  - Both wrap modulo 2^COUNTER_WIDTH.
  - A CSR write to either half replaces that half and suppresses the increment that cycle; the other half holds.
  - A carry from the low to the high half occurs only on a normal increment.
- **Reset:**
  - mstatus MIE=0, MPIE=0; mie=0; mtvec=MTVEC_RESET.
  - mscratch, mepc, mcause, mtval, mcycle, minstret all 0.
  - Outputs follow the reset state in the next cycle: o_mepc=0, o_InterruptPending=0.
  - A reset asserted mid-trap discards the trap.

Test Plan:
1. Reset, then CSRRW mscratch with 0xDEADBEEF, then CSRRS with 0x0000000F → o_OutputData=0xDEADBEEF; mscratch then reads 0xDEADBEEF (F bits already set). A following CSRRC with 0xFF00_0000 → mscratch reads 0x00ADBEEF.
2. CSRRW to mvendorid (0xF11) with write enable → o_IllegalAccess=1 and the value stays 0. Read of 0x7C0 → o_IllegalAccess=1, o_OutputData=0.
3. Set MIE=1 and mie bit 7; assert i_TimerIrq → o_InterruptPending=1. Trap with PC 0x103, cause 7, interrupt=1, mtvec=0x8001 → mepc=0x100, mcause=0x80000007, MIE=0, MPIE=1, o_TrapVector=0x801C. MRET → MIE=1.
4. Write mcycle=0xFFFFFFFF with mcycleh=0 (COUNTER_WIDTH=64) → next cycle mcycle=0, mcycleh=1. Write mcycleh on a cycle with retire=1 → minstret increments while mcycleh holds the written value.
5. Same cycle: i_ExceptionRaised, i_Mret and a CSRRW to mepc → only the trap updates take effect; the mepc write is dropped.
6. Write mtvec=0x2003 → reads 0x2000 or 0x2001 depending on the prior mode (mode preserved). Assert i_Reset mid-sequence → every register returns to its reset value the next cycle.

Source files
------------

// File: rtl/csr_file_v2.sv
// -----------------------------------------------------------------------------
// csr_file_v2
//   Writable machine-mode CSR file that sits beside the execute stage.
//   Reads are combinational. Every state change happens on the rising clock edge.
//   Edge priority: reset, then trap entry, then MRET, then the CSR write.
//
// Ports
//   i_Clock, i_Reset              clock and synchronous active-high reset
//   i_CsrNumber, i_AluOp          CSR address and funct3 (RW/RS/RC and immediate forms)
//   i_InputData                   rs1 value or zero-extended uimm
//   i_ReadEnable, i_WriteEnable   the instruction reads / writes the CSR
//   i_InstructionRetired          bumps minstret
//   i_ExceptionRaised, i_Interrupt, i_ExceptionCause,
//   i_ExceptionInstructionPointer, i_ExceptionValue
//                                 trap-entry information
//   i_Mret                        MRET executing
//   i_SoftwareIrq/TimerIrq/ExternalIrq   live interrupt lines (mip)
//   o_OutputData                  old CSR value (0 for unimplemented numbers)
//   o_IllegalAccess               the access must raise an illegal instruction
//   o_mepc, o_TrapVector          return PC and trap target PC
//   o_InterruptPending            mstatus.MIE & |(mip & mie)
// -----------------------------------------------------------------------------
module csr_file_v2 #(
  parameter logic [31:0] HART_ID       = 32'h0000_0000,
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE    = 32'h4000_0100
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [11:0] i_CsrNumber,
  input  logic [2:0]  i_AluOp,
  input  logic [31:0] i_InputData,
  input  logic        i_ReadEnable,
  input  logic        i_WriteEnable,
  input  logic        i_InstructionRetired,
  input  logic        i_ExceptionRaised,
  input  logic        i_Interrupt,
  input  logic [3:0]  i_ExceptionCause,
  input  logic [31:0] i_ExceptionInstructionPointer,
  input  logic [31:0] i_ExceptionValue,
  input  logic        i_Mret,
  input  logic        i_SoftwareIrq,
  input  logic        i_TimerIrq,
  input  logic        i_ExternalIrq,
  output logic [31:0] o_OutputData,
  output logic        o_IllegalAccess,
  output logic [31:0] o_mepc,
  output logic [31:0] o_TrapVector,
  output logic        o_InterruptPending
);

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Only the software/timer/external enable bits exist in mie/mip.
  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;
  localparam bit          WIDE_CNT = (COUNTER_WIDTH == 64);

  logic        r_StatusMie;
  logic        r_StatusMpie;
  logic [31:0] r_Mie;
  logic [31:0] r_Mtvec;
  logic [31:0] r_Mscratch;
  logic [31:0] r_Mepc;
  logic [31:0] r_Mcause;
  logic [31:0] r_Mtval;
  // Counters are held at 64 bits. At 32-bit width the upper half stays 0.
  logic [63:0] r_Mcycle;
  logic [63:0] r_Minstret;

  logic [31:0] w_Mstatus;
  logic [31:0] w_Mip;
  logic [31:0] w_OldValue;
  logic        w_Implemented;
  logic        w_OpReserved;
  logic        w_Illegal;
  logic        w_DoWrite;
  logic [31:0] w_NewValue;
  logic [31:0] w_MtvecNew;
  logic [63:0] w_CycleInc;
  logic [63:0] w_InstretInc;
  logic [63:0] w_CycleNext;
  logic [63:0] w_InstretNext;
  logic        w_WrCycleLo;
  logic        w_WrCycleHi;
  logic        w_WrInstretLo;
  logic        w_WrInstretHi;

  // Read-modify-write result for the CSRRW/S/C family (funct3[1:0] picks it).
  function automatic logic [31:0] f_new_value(input logic [1:0]  op,
                                              input logic [31:0] old,
                                              input logic [31:0] data);
    case (op)
      2'b01:   f_new_value = data;
      2'b10:   f_new_value = old | data;
      2'b11:   f_new_value = old & ~data;
      default: f_new_value = old;
    endcase
  endfunction

  assign w_Mstatus = {19'b0, 2'b11, 3'b0, r_StatusMpie, 3'b0, r_StatusMie, 3'b0};
  assign w_Mip     = {20'b0, i_ExternalIrq, 3'b0, i_TimerIrq, 3'b0, i_SoftwareIrq, 3'b0};

  always_comb begin
    w_OldValue    = 32'h0;
    w_Implemented = 1'b1;
    case (i_CsrNumber)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_OldValue = 32'h0;
      CSR_MHARTID:   w_OldValue = HART_ID;
      CSR_MSTATUS:   w_OldValue = w_Mstatus;
      CSR_MISA:      w_OldValue = MISA_VALUE;
      CSR_MIE:       w_OldValue = r_Mie;
      CSR_MTVEC:     w_OldValue = r_Mtvec;
      CSR_MSCRATCH:  w_OldValue = r_Mscratch;
      CSR_MEPC:      w_OldValue = r_Mepc;
      CSR_MCAUSE:    w_OldValue = r_Mcause;
      CSR_MTVAL:     w_OldValue = r_Mtval;
      CSR_MIP:       w_OldValue = w_Mip;
      CSR_MCYCLE:    w_OldValue = r_Mcycle[31:0];
      CSR_MINSTRET:  w_OldValue = r_Minstret[31:0];
      CSR_MCYCLEH:   w_OldValue = r_Mcycle[63:32];
      CSR_MINSTRETH: w_OldValue = r_Minstret[63:32];
      default:       w_Implemented = 1'b0;
    endcase
  end

  // funct3 000 and 100 both have [1:0] == 00.
  assign w_OpReserved = (i_AluOp[1:0] == 2'b00);
  // Number space [11:10] == 11 is read-only.
  assign w_Illegal = ((i_ReadEnable | i_WriteEnable) & (~w_Implemented | w_OpReserved)) |
                     (i_WriteEnable & (i_CsrNumber[11:10] == 2'b11));
  // Trap entry and MRET take the whole edge, so a CSR write beside them is dropped.
  assign w_DoWrite  = i_WriteEnable & ~w_Illegal & ~i_ExceptionRaised & ~i_Mret;
  assign w_NewValue = f_new_value(i_AluOp[1:0], w_OldValue, i_InputData);
  // Reserved mtvec modes (2, 3) keep the previous mode. The base is still taken.
  assign w_MtvecNew = {w_NewValue[31:2], w_NewValue[1] ? r_Mtvec[1:0] : w_NewValue[1:0]};

  assign w_WrCycleLo   = w_DoWrite & (i_CsrNumber == CSR_MCYCLE);
  assign w_WrInstretLo = w_DoWrite & (i_CsrNumber == CSR_MINSTRET);
  assign w_WrCycleHi   = w_DoWrite & (i_CsrNumber == CSR_MCYCLEH)   & WIDE_CNT;
  assign w_WrInstretHi = w_DoWrite & (i_CsrNumber == CSR_MINSTRETH) & WIDE_CNT;

  assign w_CycleInc    = r_Mcycle + 64'd1;
  assign w_InstretInc  = r_Minstret + {63'd0, i_InstructionRetired};
  assign w_CycleNext   = WIDE_CNT ? w_CycleInc   : {32'h0, w_CycleInc[31:0]};
  assign w_InstretNext = WIDE_CNT ? w_InstretInc : {32'h0, w_InstretInc[31:0]};

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_StatusMie  <= 1'b0;
      r_StatusMpie <= 1'b0;
      r_Mie        <= 32'h0;
      r_Mtvec      <= MTVEC_RESET;
      r_Mscratch   <= 32'h0;
      r_Mepc       <= 32'h0;
      r_Mcause     <= 32'h0;
      r_Mtval      <= 32'h0;
      r_Mcycle     <= 64'h0;
      r_Minstret   <= 64'h0;
    end else begin
      if (i_ExceptionRaised) begin
        r_Mepc       <= {i_ExceptionInstructionPointer[31:2], 2'b00};
        r_Mcause     <= {i_Interrupt, 27'b0, i_ExceptionCause};
        r_Mtval      <= i_ExceptionValue;
        r_StatusMpie <= r_StatusMie;
        r_StatusMie  <= 1'b0;
      end else if (i_Mret) begin
        r_StatusMie  <= r_StatusMpie;
        r_StatusMpie <= 1'b1;
      end else if (w_DoWrite) begin
        case (i_CsrNumber)
          CSR_MSTATUS: begin
            r_StatusMie  <= w_NewValue[3];
            r_StatusMpie <= w_NewValue[7];
          end
          CSR_MIE:      r_Mie      <= w_NewValue & IRQ_MASK;
          CSR_MTVEC:    r_Mtvec    <= w_MtvecNew;
          CSR_MSCRATCH: r_Mscratch <= w_NewValue;
          CSR_MEPC:     r_Mepc     <= {w_NewValue[31:2], 2'b00};
          CSR_MCAUSE:   r_Mcause   <= w_NewValue;
          CSR_MTVAL:    r_Mtval    <= w_NewValue;
          default: ;
        endcase
      end

      // A write to one half replaces it and freezes the other half (no carry).
      if (w_WrCycleLo)      r_Mcycle[31:0]  <= w_NewValue;
      else if (w_WrCycleHi) r_Mcycle[63:32] <= w_NewValue;
      else                  r_Mcycle        <= w_CycleNext;

      if (w_WrInstretLo)      r_Minstret[31:0]  <= w_NewValue;
      else if (w_WrInstretHi) r_Minstret[63:32] <= w_NewValue;
      else                    r_Minstret        <= w_InstretNext;
    end
  end

  assign o_OutputData       = w_OldValue;
  assign o_IllegalAccess    = w_Illegal;
  assign o_mepc             = r_Mepc;
  assign o_InterruptPending = r_StatusMie & |(w_Mip & r_Mie);

  // Vectored mode (1) offsets interrupts by 4*cause. Everything else uses the base.
  always_comb begin
    o_TrapVector = {r_Mtvec[31:2], 2'b00};
    if ((r_Mtvec[1:0] == 2'b01) && i_Interrupt)
      o_TrapVector = {r_Mtvec[31:2], 2'b00} + {26'b0, i_ExceptionCause, 2'b00};
  end

endmodule

// File: tb/tb_csr_file_v2.sv
module tb_csr_file_v2;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic [11:0] i_CsrNumber;
  logic [2:0]  i_AluOp;
  logic [31:0] i_InputData;
  logic        i_ReadEnable;
  logic        i_WriteEnable;
  logic        i_InstructionRetired;
  logic        i_ExceptionRaised;
  logic        i_Interrupt;
  logic [3:0]  i_ExceptionCause;
  logic [31:0] i_ExceptionInstructionPointer;
  logic [31:0] i_ExceptionValue;
  logic        i_Mret;
  logic        i_SoftwareIrq;
  logic        i_TimerIrq;
  logic        i_ExternalIrq;
  logic [31:0] o_OutputData;
  logic        o_IllegalAccess;
  logic [31:0] o_mepc;
  logic [31:0] o_TrapVector;
  logic        o_InterruptPending;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  csr_file_v2 #(
    .HART_ID(32'h0), .COUNTER_WIDTH(64), .MTVEC_RESET(32'h0), .MISA_VALUE(32'h4000_0100)
  ) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_CsrNumber(i_CsrNumber), .i_AluOp(i_AluOp),
    .i_InputData(i_InputData), .i_ReadEnable(i_ReadEnable), .i_WriteEnable(i_WriteEnable),
    .i_InstructionRetired(i_InstructionRetired), .i_ExceptionRaised(i_ExceptionRaised),
    .i_Interrupt(i_Interrupt), .i_ExceptionCause(i_ExceptionCause),
    .i_ExceptionInstructionPointer(i_ExceptionInstructionPointer),
    .i_ExceptionValue(i_ExceptionValue), .i_Mret(i_Mret), .i_SoftwareIrq(i_SoftwareIrq),
    .i_TimerIrq(i_TimerIrq), .i_ExternalIrq(i_ExternalIrq), .o_OutputData(o_OutputData),
    .o_IllegalAccess(o_IllegalAccess), .o_mepc(o_mepc), .o_TrapVector(o_TrapVector),
    .o_InterruptPending(o_InterruptPending)
  );

  always #5 i_Clock = ~i_Clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Interrupt lines are left alone here; tests drive them explicitly.
  task automatic idle();
    i_Reset = 0; i_CsrNumber = 0; i_AluOp = 0; i_InputData = 0;
    i_ReadEnable = 0; i_WriteEnable = 0; i_InstructionRetired = 0;
    i_ExceptionRaised = 0; i_Interrupt = 0; i_ExceptionCause = 0;
    i_ExceptionInstructionPointer = 0; i_ExceptionValue = 0; i_Mret = 0;
  endtask

  task automatic step();
    @(posedge i_Clock);
    #1;
    idle();
    #1;
  endtask

  task automatic csr_op(input logic [11:0] num, input logic [2:0] op, input logic [31:0] data);
    i_CsrNumber = num; i_AluOp = op; i_InputData = data;
    i_ReadEnable = 1; i_WriteEnable = 1;
    #1;
  endtask

  task automatic read_csr(input logic [11:0] num, output logic [31:0] d);
    i_CsrNumber = num; i_AluOp = 3'b010; i_InputData = 0;
    i_ReadEnable = 1; i_WriteEnable = 0;
    #1;
    d = o_OutputData;
    idle();
    #1;
  endtask

  task automatic test_reset();
    i_SoftwareIrq = 0; i_TimerIrq = 0; i_ExternalIrq = 0;
    idle();
    i_Reset = 1;
    @(posedge i_Clock); #1;
    @(posedge i_Clock); #1;
    idle(); #1;
    read_csr(12'hB00, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mcycle got %h exp %h", rd, 32'h0); end
    checks++; if (o_mepc !== 32'h0) begin errors++; $display("FAIL reset_mepc got %h exp %h", o_mepc, 32'h0); end
    checks++; if (o_InterruptPending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", o_InterruptPending); end
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", rd, 32'h1800); end
    read_csr(12'h305, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mtvec got %h exp %h", rd, 32'h0); end
  endtask

  task automatic test_rw_set_clear();
    csr_op(12'h340, 3'b001, 32'hDEAD_BEEF);
    checks++; if (o_IllegalAccess !== 1'b0) begin errors++; $display("FAIL rw_legal got %b exp 0", o_IllegalAccess); end
    step();
    csr_op(12'h340, 3'b010, 32'h0000_000F);
    checks++; if (o_OutputData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_old got %h exp %h", o_OutputData, 32'hDEADBEEF); end
    step();
    read_csr(12'h340, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_result got %h exp %h", rd, 32'hDEADBEEF); end
    csr_op(12'h340, 3'b111, 32'hFF00_0000);
    step();
    read_csr(12'h340, rd);
    checks++; if (rd !== 32'h00AD_BEEF) begin errors++; $display("FAIL rc_result got %h exp %h", rd, 32'h00ADBEEF); end
  endtask

  task automatic test_illegal();
    csr_op(12'hF11, 3'b001, 32'h1234_5678);
    checks++; if (o_IllegalAccess !== 1'b1) begin errors++; $display("FAIL ro_write_illegal got %b exp 1", o_IllegalAccess); end
    step();
    read_csr(12'hF11, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mvendorid_val got %h exp 0", rd); end
    i_CsrNumber = 12'h7C0; i_AluOp = 3'b010; i_ReadEnable = 1; #1;
    checks++; if (o_IllegalAccess !== 1'b1) begin errors++; $display("FAIL unimpl_illegal got %b exp 1", o_IllegalAccess); end
    checks++; if (o_OutputData !== 32'h0) begin errors++; $display("FAIL unimpl_data got %h exp 0", o_OutputData); end
    idle();
    csr_op(12'h340, 3'b100, 32'hFFFF_FFFF);
    checks++; if (o_IllegalAccess !== 1'b1) begin errors++; $display("FAIL reserved_op got %b exp 1", o_IllegalAccess); end
    step();
    read_csr(12'h340, rd);
    checks++; if (rd !== 32'h00AD_BEEF) begin errors++; $display("FAIL reserved_nowrite got %h exp %h", rd, 32'h00ADBEEF); end
    csr_op(12'h301, 3'b001, 32'h0);
    step();
    read_csr(12'h301, rd);
    checks++; if (rd !== 32'h4000_0100) begin errors++; $display("FAIL misa got %h exp %h", rd, 32'h40000100); end
  endtask

  task automatic test_trap_mret();
    csr_op(12'h300, 3'b001, 32'h0000_0008); step();
    csr_op(12'h304, 3'b001, 32'hFFFF_FFFF); step();
    read_csr(12'h304, rd);
    checks++; if (rd !== 32'h0000_0888) begin errors++; $display("FAIL mie_mask got %h exp %h", rd, 32'h888); end
    csr_op(12'h304, 3'b001, 32'h0000_0080); step();
    csr_op(12'h305, 3'b001, 32'h0000_8001); step();
    checks++; if (o_InterruptPending !== 1'b0) begin errors++; $display("FAIL pending_noirq got %b exp 0", o_InterruptPending); end
    i_TimerIrq = 1; #1;
    checks++; if (o_InterruptPending !== 1'b1) begin errors++; $display("FAIL pending_timer got %b exp 1", o_InterruptPending); end
    read_csr(12'h344, rd);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL mip got %h exp %h", rd, 32'h80); end
    i_ExceptionRaised = 1; i_Interrupt = 1; i_ExceptionCause = 4'd7;
    i_ExceptionInstructionPointer = 32'h103; i_ExceptionValue = 32'hABCD; #1;
    checks++; if (o_TrapVector !== 32'h0000_801C) begin errors++; $display("FAIL vec_irq got %h exp %h", o_TrapVector, 32'h801C); end
    i_Interrupt = 0; #1;
    checks++; if (o_TrapVector !== 32'h0000_8000) begin errors++; $display("FAIL vec_exc got %h exp %h", o_TrapVector, 32'h8000); end
    i_Interrupt = 1; #1;
    step();
    checks++; if (o_mepc !== 32'h0000_0100) begin errors++; $display("FAIL trap_mepc got %h exp %h", o_mepc, 32'h100); end
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause got %h exp %h", rd, 32'h80000007); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL trap_mtval got %h exp %h", rd, 32'hABCD); end
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1880) begin errors++; $display("FAIL trap_mstatus got %h exp %h", rd, 32'h1880); end
    checks++; if (o_InterruptPending !== 1'b0) begin errors++; $display("FAIL trap_pending got %b exp 0", o_InterruptPending); end
    i_Mret = 1; step();
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus got %h exp %h", rd, 32'h1888); end
    checks++; if (o_InterruptPending !== 1'b1) begin errors++; $display("FAIL mret_pending got %b exp 1", o_InterruptPending); end
    i_TimerIrq = 0; #1;
  endtask

  task automatic test_counters();
    csr_op(12'hB80, 3'b001, 32'h0); step();
    csr_op(12'hB00, 3'b001, 32'hFFFF_FFFF); step();
    read_csr(12'hB00, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_wr got %h exp %h", rd, 32'hFFFFFFFF); end
    step();
    read_csr(12'hB00, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got %h exp 0", rd); end
    read_csr(12'hB80, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got %h exp 1", rd); end
    csr_op(12'hB80, 3'b001, 32'h0000_0055); i_InstructionRetired = 1; #1; step();
    read_csr(12'hB80, rd);
    checks++; if (rd !== 32'h0000_0055) begin errors++; $display("FAIL mcycleh_wr got %h exp %h", rd, 32'h55); end
    read_csr(12'hB02, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL minstret_inc got %h exp 1", rd); end
    csr_op(12'hB02, 3'b001, 32'h10); i_InstructionRetired = 1; #1; step();
    read_csr(12'hB02, rd);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL minstret_wr got %h exp %h", rd, 32'h10); end
    i_InstructionRetired = 1; step();
    read_csr(12'hB02, rd);
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL minstret_next got %h exp %h", rd, 32'h11); end
    read_csr(12'hB82, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL minstreth got %h exp 0", rd); end
  endtask

  task automatic test_priority();
    csr_op(12'h341, 3'b001, 32'h0000_0203); step();
    checks++; if (o_mepc !== 32'h0000_0200) begin errors++; $display("FAIL mepc_align got %h exp %h", o_mepc, 32'h200); end
    // MIE=1, MPIE=1 here; trap beats MRET and the mepc write.
    csr_op(12'h341, 3'b001, 32'h0000_0999);
    i_ExceptionRaised = 1; i_Interrupt = 0; i_ExceptionCause = 4'd2;
    i_ExceptionInstructionPointer = 32'h404; i_ExceptionValue = 32'h77; i_Mret = 1; #1;
    step();
    checks++; if (o_mepc !== 32'h0000_0404) begin errors++; $display("FAIL prio_mepc got %h exp %h", o_mepc, 32'h404); end
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL prio_mcause got %h exp 2", rd); end
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1880) begin errors++; $display("FAIL prio_mstatus got %h exp %h", rd, 32'h1880); end
    // MRET beats a same-cycle mstatus write.
    csr_op(12'h300, 3'b001, 32'h0); i_Mret = 1; #1; step();
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1888) begin errors++; $display("FAIL mret_vs_write got %h exp %h", rd, 32'h1888); end
  endtask

  task automatic test_mtvec_and_reset();
    csr_op(12'h305, 3'b001, 32'h0000_2003); step();
    read_csr(12'h305, rd);
    checks++; if (rd !== 32'h0000_2001) begin errors++; $display("FAIL mtvec_keep1 got %h exp %h", rd, 32'h2001); end
    csr_op(12'h305, 3'b001, 32'h0000_3000); step();
    csr_op(12'h305, 3'b001, 32'h0000_2003); step();
    read_csr(12'h305, rd);
    checks++; if (rd !== 32'h0000_2000) begin errors++; $display("FAIL mtvec_keep0 got %h exp %h", rd, 32'h2000); end
    i_Reset = 1; i_ExceptionRaised = 1; i_ExceptionInstructionPointer = 32'h500;
    i_ExceptionCause = 4'd3; i_ExceptionValue = 32'h9; #1;
    @(posedge i_Clock); #1; idle(); #1;
    checks++; if (o_mepc !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h exp 0", o_mepc); end
    checks++; if (o_InterruptPending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", o_InterruptPending); end
    read_csr(12'hB00, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mcycle got %h exp 0", rd); end
    read_csr(12'h340, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mscratch got %h exp 0", rd); end
    read_csr(12'h342, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mcause got %h exp 0", rd); end
    read_csr(12'h343, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mtval got %h exp 0", rd); end
    read_csr(12'h304, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mie got %h exp 0", rd); end
    read_csr(12'h305, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mtvec got %h exp 0", rd); end
    read_csr(12'h300, rd);
    checks++; if (rd !== 32'h0000_1800) begin errors++; $display("FAIL rst_mstatus got %h exp %h", rd, 32'h1800); end
    read_csr(12'hB80, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mcycleh got %h exp 0", rd); end
    read_csr(12'hB02, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_minstret got %h exp 0", rd); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_rw_set_clear();
    test_illegal();
    test_trap_mret();
    test_counters();
    test_priority();
    test_mtvec_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
